// File: rtl/cpu_branch_pkg.sv
// cpu_branch_pkg: types and constants shared by branch_unit, branch_cond and the
// decoder's cycle predictor.
//   state_e        branch sequencer states (encoding owned here)
//   Flag*          bit positions of the status flags inside P
//   Sel*           flag-select codes carried in opcode[7:6]
package cpu_branch_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StWaitOff = 3'd1,
    StAdd     = 3'd2,
    StFix     = 3'd3,
    StDone    = 3'd4
  } state_e;

  // Status register bit positions.
  localparam int unsigned FlagN = 7;
  localparam int unsigned FlagV = 6;
  localparam int unsigned FlagZ = 1;
  localparam int unsigned FlagC = 0;

  // opcode[7:6] flag-select codes.
  localparam logic [1:0] SelN = 2'b00;
  localparam logic [1:0] SelV = 2'b01;
  localparam logic [1:0] SelC = 2'b10;
  localparam logic [1:0] SelZ = 2'b11;

endpackage

// File: rtl/branch_unit_if.sv
// branch_unit_if: bundle between the decoder/datapath (master) and the
// branch sequencer (slave).
//   start, opcode                 branch opcode handoff from the decoder
//   flags, offset_valid, offset   operand byte and status register
//   pc                            PC low byte, already past the operand
//   branch, branch_load           new PC low byte and its load strobe
//   pch_inc, pch_dec              PC high byte fix-up strobes
//   taken, busy, done             status back to the core
interface branch_unit_if;

  logic       start;
  logic [7:0] opcode;
  logic [7:0] flags;
  logic       offset_valid;
  logic [7:0] offset;
  logic [7:0] pc;
  logic [7:0] branch;
  logic       branch_load;
  logic       pch_inc;
  logic       pch_dec;
  logic       taken;
  logic       busy;
  logic       done;

  modport master (
    output start, opcode, flags, offset_valid, offset, pc,
    input  branch, branch_load, pch_inc, pch_dec, taken, busy, done
  );

  modport slave (
    input  start, opcode, flags, offset_valid, offset, pc,
    output branch, branch_load, pch_inc, pch_dec, taken, busy, done
  );

endinterface

// File: rtl/branch_cond.sv
// branch_cond: combinational 6502 branch-condition decode.
//   sel_i    opcode[7:5]: [2:1] selects N/V/C/Z, [0] is the required flag value
//   flags_i  status register P
//   cond_o   1 when the branch is taken
// Shared with the decoder so its cycle prediction matches the sequencer.
module branch_cond
  import cpu_branch_pkg::*;
(
  input  logic [2:0] sel_i,
  input  logic [7:0] flags_i,
  output logic       cond_o
);

  logic flag;

  // P bits 5:2 (unused, B, D, I) never steer a branch.
  logic unused_flags;
  assign unused_flags = ^flags_i[5:2];

  always_comb begin
    flag = 1'b0;
    case (sel_i[2:1])
      SelN:    flag = flags_i[FlagN];
      SelV:    flag = flags_i[FlagV];
      SelC:    flag = flags_i[FlagC];
      SelZ:    flag = flags_i[FlagZ];
      default: flag = 1'b0;
    endcase
    cond_o = (flag == sel_i[0]);
  end

endmodule

// File: rtl/branch_unit.sv
// branch_unit: relative-branch sequencer feeding the program counter.
//   clk, rst  clock and synchronous active-high reset
//   bus       branch_unit_if.slave (opcode/operand in, PC load and fix-up out)
// Timing, with N the cycle offset_valid is accepted: not taken -> done at N+1;
// taken -> branch_load at N+1, done at N+2; a page cross adds a FIX cycle
// (pch_* at N+2, done at N+3) only when BRANCH_PAGE_PENALTY_EN is defined.
// Without it the FIX state is absent and pch_* fire alongside branch_load.
// Every output is decoded from flops; no input reaches an output directly.
module branch_unit
  import cpu_branch_pkg::*;
(
  input logic          clk,
  input logic          rst,
  branch_unit_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] cond_sel_q, cond_sel_d;
  logic [7:0] branch_q, branch_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       taken_q, taken_d;

  logic       cond;
  logic [8:0] sum;

  // Only the condition field of the opcode matters here.
  logic unused_opcode;
  assign unused_opcode = ^bus.opcode[4:0];

  branch_cond u_branch_cond (
    .sel_i   (cond_sel_q),
    .flags_i (bus.flags),
    .cond_o  (cond)
  );

  // Unsigned 9-bit add: the carry out combined with the offset sign tells
  // which way (if any) the high byte has to move.
  assign sum = {1'b0, bus.pc} + {1'b0, bus.offset};

  always_comb begin
    state_d    = state_q;
    cond_sel_d = cond_sel_q;
    branch_d   = branch_q;
    inc_d      = inc_q;
    dec_d      = dec_q;
    taken_d    = taken_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          cond_sel_d = bus.opcode[7:5];
          state_d    = StWaitOff;
        end
      end

      StWaitOff: begin
        if (bus.offset_valid) begin
          if (cond) begin
            branch_d = sum[7:0];
            inc_d    = ~bus.offset[7] & sum[8];
            dec_d    = bus.offset[7] & ~sum[8];
            taken_d  = 1'b1;
            state_d  = StAdd;
          end else begin
            state_d  = StDone;
          end
        end
      end

      StAdd: begin
`ifdef BRANCH_PAGE_PENALTY_EN
        state_d = (inc_q | dec_q) ? StFix : StDone;
`else
        state_d = StDone;
`endif
      end

`ifdef BRANCH_PAGE_PENALTY_EN
      StFix: begin
        state_d = StDone;
      end
`endif

      StDone: begin
        // branch_q deliberately holds until the next taken branch.
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        taken_d = 1'b0;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cond_sel_q <= 3'b000;
      branch_q   <= 8'h00;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cond_sel_q <= cond_sel_d;
      branch_q   <= branch_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      taken_q    <= taken_d;
    end
  end

  assign bus.branch      = branch_q;
  assign bus.branch_load = (state_q == StAdd);
  assign bus.taken       = taken_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = (state_q == StDone);

`ifdef BRANCH_PAGE_PENALTY_EN
  assign bus.pch_inc = (state_q == StFix) & inc_q;
  assign bus.pch_dec = (state_q == StFix) & dec_q;
`else
  assign bus.pch_inc = (state_q == StAdd) & inc_q;
  assign bus.pch_dec = (state_q == StAdd) & dec_q;
`endif

  // A single add cannot carry and borrow at once.
  assert property (@(posedge clk) disable iff (rst) !(bus.pch_inc && bus.pch_dec));
  assert property (@(posedge clk) disable iff (rst) bus.done |=> !bus.done);
  assert property (@(posedge clk) disable iff (rst) bus.branch_load |=> !bus.branch_load);

endmodule

// File: tb/tb_branch_unit.sv
module tb_branch_unit;

`ifdef BRANCH_PAGE_PENALTY_EN
  localparam bit Pen = 1'b1;
`else
  localparam bit Pen = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] last_br = 8'h00;

  branch_unit_if bus ();

  branch_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] opc;
    logic [7:0] flg;
    logic [7:0] pcv;
    logic [7:0] off;
    bit         tk;
    logic [7:0] br;
    bit         inc;
    bit         dec;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: evaluate the condition from the flag table and do the branch on a
  // full 16-bit PC; a page cross is simply a change of high byte.
  task automatic model(input logic [7:0] opc, input logic [7:0] flg, input logic [7:0] pcv,
                       input logic [7:0] off, output bit tk, output logic [7:0] br,
                       output bit inc, output bit dec);
    int flag_pos[4];
    int old_pc, new_pc, soff;
    flag_pos = '{7, 6, 0, 1};
    tk = (flg[flag_pos[opc[7:6]]] == opc[5]);
    old_pc = 32'h4000 + int'(pcv);
    soff = int'(off);
    if (off[7]) soff = soff - 256;
    new_pc = old_pc + soff;
    br  = tk ? 8'(new_pc) : last_br;
    inc = tk && ((new_pc >> 8) > (old_pc >> 8));
    dec = tk && ((new_pc >> 8) < (old_pc >> 8));
  endtask

  function automatic logic [13:0] outs();
    return {bus.branch, bus.branch_load, bus.pch_inc, bus.pch_dec, bus.taken, bus.busy,
            bus.done};
  endfunction

  // Called at a negedge with the unit idle; returns at a negedge with it idle.
  task automatic do_branch(input string nm, input logic [7:0] opc, input logic [7:0] flg,
                           input logic [7:0] pcv, input logic [7:0] off, input int gap,
                           input bit noise, input bit tk, input logic [7:0] br,
                           input bit inc, input bit dec);
    logic [3:0] g_bl, g_inc, g_dec, g_dn, g_tk, g_bs;
    logic [3:0] e_bl, e_inc, e_dec, e_dn, e_tk, e_bs;
    logic [7:0] g_br1;
    int dk, pk;
    bit seen;
    // Stray operand strobe while idle must not start anything.
    bus.start = 1'b0;
    bus.offset_valid = 1'b1;
    bus.offset = 8'hAA;
    @(negedge clk);
    check({nm, " idle_ov busy"}, bus.busy, 0);
    bus.start = 1'b1;
    bus.opcode = opc;
    bus.offset_valid = noise;
    bus.offset = ~off;
    bus.pc = ~pcv;
    bus.flags = ~flg;
    @(negedge clk);
    check({nm, " wait"}, {bus.busy, bus.done, bus.branch_load}, 3'b100);
    bus.start = noise;
    bus.opcode = ~opc;
    bus.offset_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check({nm, " wait_gap"}, {bus.busy, bus.done, bus.branch_load}, 3'b100);
    end
    bus.offset_valid = 1'b1;
    bus.flags = flg;
    bus.pc = pcv;
    bus.offset = off;
    seen = 1'b0;
    g_br1 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      g_bl[k]  = bus.branch_load;
      g_inc[k] = bus.pch_inc;
      g_dec[k] = bus.pch_dec;
      g_dn[k]  = bus.done;
      g_tk[k]  = bus.taken;
      g_bs[k]  = bus.busy;
      if (k == 0) g_br1 = bus.branch;
      bus.offset_valid = 1'b0;
      bus.flags = 8'($urandom);
      bus.pc = 8'($urandom);
      bus.offset = 8'($urandom);
      bus.start = noise && !seen;
      if (bus.done) seen = 1'b1;
    end
    bus.start = 1'b0;
    pk = Pen ? 1 : 0;
    dk = !tk ? 0 : ((inc || dec) && Pen) ? 2 : 1;
    e_dn  = 4'(1 << dk);
    e_bs  = 4'((2 << dk) - 1);
    e_tk  = tk ? e_bs : 4'b0000;
    e_bl  = tk ? 4'b0001 : 4'b0000;
    e_inc = inc ? 4'(1 << pk) : 4'b0000;
    e_dec = dec ? 4'(1 << pk) : 4'b0000;
    check({nm, " branch_load"}, g_bl, e_bl);
    check({nm, " pch_inc"}, g_inc, e_inc);
    check({nm, " pch_dec"}, g_dec, e_dec);
    check({nm, " done"}, g_dn, e_dn);
    check({nm, " taken"}, g_tk, e_tk);
    check({nm, " busy"}, g_bs, e_bs);
    check({nm, " branch_n1"}, g_br1, br);
    check({nm, " branch_hold"}, bus.branch, br);
    last_br = br;
  endtask

  // BCC across a page, reset in ADD (stage 0) or FIX (stage 1).
  task automatic rst_seq(input string nm, input int stage);
    bus.start = 1'b1;
    bus.opcode = 8'h90;
    @(negedge clk);
    bus.start = 1'b0;
    bus.offset_valid = 1'b1;
    bus.flags = 8'h00;
    bus.pc = 8'hF0;
    bus.offset = 8'h20;
    @(negedge clk);
    bus.offset_valid = 1'b0;
    check({nm, " pre add"}, bus.branch_load, 1);
    if (stage == 1) begin
      @(negedge clk);
      check({nm, " pre fix"}, bus.pch_inc, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check({nm, " outputs"}, outs(), 14'h0000);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({nm, " after"},
            {bus.pch_inc, bus.pch_dec, bus.done, bus.busy, bus.branch_load}, 5'b00000);
    end
    last_br = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[10];
    logic [7:0] ro, rf, rp, rof, rbr;
    bit rtk, rinc, rdec;
    vt[0] = '{"beq_fwd",   8'hF0, 8'h02, 8'h10, 8'h05, 1'b1, 8'h15, 1'b0, 1'b0};
    vt[1] = '{"bne_nt",    8'hD0, 8'h02, 8'h33, 8'h44, 1'b0, 8'h15, 1'b0, 1'b0};
    vt[2] = '{"bcc_cross", 8'h90, 8'h00, 8'hF0, 8'h20, 1'b1, 8'h10, 1'b1, 1'b0};
    vt[3] = '{"bmi_back",  8'h30, 8'h80, 8'h05, 8'hF0, 1'b1, 8'hF5, 1'b0, 1'b1};
    vt[4] = '{"bmi_nox",   8'h30, 8'h80, 8'h20, 8'hFE, 1'b1, 8'h1E, 1'b0, 1'b0};
    vt[5] = '{"bvs_7f",    8'h70, 8'h40, 8'h7F, 8'h01, 1'b1, 8'h80, 1'b0, 1'b0};
    vt[6] = '{"bcs_ff",    8'hB0, 8'h01, 8'hFF, 8'h01, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7] = '{"bpl_nt",    8'h10, 8'h80, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[8] = '{"bvc_nt",    8'h50, 8'h40, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[9] = '{"bne_m128",  8'hD0, 8'h00, 8'h81, 8'h80, 1'b1, 8'h01, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.opcode = 8'h00;
    bus.flags = 8'h00;
    bus.offset_valid = 1'b0;
    bus.offset = 8'h00;
    bus.pc = 8'h00;
    repeat (3) @(negedge clk);
    check("reset outputs", outs(), 14'h0000);
    rst = 1'b0;
    @(negedge clk);
    check("post reset idle", outs(), 14'h0000);

    for (int i = 0; i < 10; i++) begin
      do_branch(vt[i].name, vt[i].opc, vt[i].flg, vt[i].pcv, vt[i].off, i % 3, bit'(i % 2),
                vt[i].tk, vt[i].br, vt[i].inc, vt[i].dec);
    end

    rst_seq("rst_in_add", 0);
`ifdef BRANCH_PAGE_PENALTY_EN
    rst_seq("rst_in_fix", 1);
`endif

    for (int i = 0; i < 40; i++) begin
      ro  = {3'($urandom), 5'b10000};
      rf  = 8'($urandom);
      rp  = 8'($urandom);
      rof = 8'($urandom);
      model(ro, rf, rp, rof, rtk, rbr, rinc, rdec);
      do_branch($sformatf("rand%0d", i), ro, rf, rp, rof, int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), rtk, rbr, rinc, rdec);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
